dm_cache: RTL and testbench

DM_CACHE -- requirements
Module: dm_cache

---
 rtl/mem_pkg.sv | 17 +
 rtl/dm_cache_tag_store.sv | 36 +++
 rtl/dm_cache.sv | 193 +++++++++++++++++++
 tb/tb_dm_cache.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default geometry for the direct-mapped cache.
package mem_pkg;
  localparam int DEF_ADDR_W = 26;
  localparam int DEF_LINES  = 16;
  localparam int DEF_WORDS  = 4;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, FLUSH, FILL, THRU_RD, THRU_WR, RESP
  } state_t;

  typedef struct packed {
    logic w_line;
    logic r_line;
    logic w_one;
    logic r_one;
  } strb_t;
endpackage

// File: rtl/dm_cache_tag_store.sv
// Per-line valid/dirty/tag: combinational read by index, one synchronous write port.
module dm_cache_tag_store #(
  parameter int LINES = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 20
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_valid,
  output logic             o_dirty,
  output logic [TAG_W-1:0] o_tag,
  input  logic             i_wr,
  input  logic             i_valid,
  input  logic             i_dirty,
  input  logic [TAG_W-1:0] i_tag
);
  logic [LINES-1:0]            r_valid, r_dirty;
  logic [LINES-1:0][TAG_W-1:0] r_tag;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_valid <= '0;
      r_dirty <= '0;
      r_tag   <= '0;
    end else if (i_wr) begin
      r_valid[i_idx] <= i_valid;
      r_dirty[i_idx] <= i_dirty;
      r_tag[i_idx]   <= i_tag;
    end
  end

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
endmodule

// File: rtl/dm_cache.sv
// Direct-mapped write-back cache with per-request bypass (through) mode.
// Optional hit/miss counters under DM_CACHE_STATS_EN.
module dm_cache import mem_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINES  = DEF_LINES,
  parameter int WORDS  = DEF_WORDS
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic                w_en,
  input  logic                r_en,
  input  logic                write_through,
  input  logic                read_through,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [31:0]         data_store,
  output logic [31:0]         data_load,
  output logic                done,
  output logic                cache_hit,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_w_line,
  output logic                mem_r_line,
  output logic                mem_w_one,
  output logic                mem_r_one,
  output logic [WORDS*32-1:0] line_store,
  input  logic [WORDS*32-1:0] line_read,
  input  logic                mem_done
`ifdef DM_CACHE_STATS_EN
  , output logic [31:0]       hit_count
  , output logic [31:0]       miss_count
`endif
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  state_t                          r_state;
  strb_t                           r_strb;
  logic                            r_is_wr, r_thru, r_first;
  logic [LINES-1:0][WORDS-1:0][31:0] r_data;
  logic [WORDS-1:0][31:0]          r_line_store;

  logic [OFF_W-1:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag, w_tag_rd, w_ts_tag;
  logic             w_valid, w_dirty, w_hit, w_active;
  logic             w_ts_wr, w_ts_valid, w_ts_dirty;

  assign w_off    = addr[OFF_W-1:0];
  assign w_idx    = addr[OFF_W +: IDX_W];
  assign w_tag    = addr[ADDR_W-1 -: TAG_W];
  assign w_hit    = w_valid && (w_tag_rd == w_tag);
  assign w_active = r_is_wr ? w_en : r_en;

  assign mem_w_line = r_strb.w_line;
  assign mem_r_line = r_strb.r_line;
  assign mem_w_one  = r_strb.w_one;
  assign mem_r_one  = r_strb.r_one;
  assign line_store = r_line_store;

  dm_cache_tag_store #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_tags (
    .clk     (clk),
    .rst_l   (rst_l),
    .i_idx   (w_idx),
    .o_valid (w_valid),
    .o_dirty (w_dirty),
    .o_tag   (w_tag_rd),
    .i_wr    (w_ts_wr),
    .i_valid (w_ts_valid),
    .i_dirty (w_ts_dirty),
    .i_tag   (w_ts_tag)
  );

  // Tag-store updates land on the same edge as the FSM step that causes them,
  // so LOOKUP after FILL sees the new tag.
  always_comb begin
    w_ts_wr    = 1'b0;
    w_ts_valid = w_valid;
    w_ts_dirty = w_dirty;
    w_ts_tag   = w_tag_rd;
    case (r_state)
      LOOKUP: if (w_active && !r_thru && w_hit && r_is_wr) begin
        w_ts_wr    = 1'b1;
        w_ts_dirty = 1'b1;
      end
      FLUSH: if (r_strb.w_line && mem_done) begin
        w_ts_wr    = 1'b1;
        w_ts_dirty = 1'b0;
      end
      FILL: if (r_strb.r_line && mem_done) begin
        w_ts_wr    = 1'b1;
        w_ts_valid = 1'b1;
        w_ts_dirty = 1'b0;
        w_ts_tag   = w_tag;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state      <= IDLE;
      r_strb       <= '0;
      r_is_wr      <= 1'b0;
      r_thru       <= 1'b0;
      r_first      <= 1'b0;
      r_data       <= '0;
      r_line_store <= '0;
      data_load    <= '0;
      done         <= 1'b0;
      cache_hit    <= 1'b0;
      mem_addr     <= '0;
`ifdef DM_CACHE_STATS_EN
      hit_count    <= '0;
      miss_count   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_en || r_en) begin
          r_is_wr <= w_en;
          r_thru  <= w_en ? write_through : read_through;
          r_first <= 1'b1;
          r_state <= LOOKUP;
        end
        LOOKUP: begin
          r_first <= 1'b0;
`ifdef DM_CACHE_STATS_EN
          if (w_active && !r_thru && r_first) begin
            if (w_hit) begin
              if (hit_count != '1) hit_count <= hit_count + 32'd1;
            end else if (miss_count != '1) miss_count <= miss_count + 32'd1;
          end
`endif
          if (!w_active) r_state <= IDLE;
          else if (r_thru) begin
            if (w_hit && w_dirty) r_state <= FLUSH;
            else                  r_state <= r_is_wr ? THRU_WR : THRU_RD;
          end else if (w_hit) begin
            if (r_is_wr) r_data[w_idx][w_off] <= data_store;
            else         data_load <= r_data[w_idx][w_off];
            done      <= 1'b1;
            cache_hit <= r_first;
            r_state   <= RESP;
          end else r_state <= (w_valid && w_dirty) ? FLUSH : FILL;
        end
        FLUSH: if (!r_strb.w_line) begin
          r_strb.w_line <= 1'b1;
          mem_addr      <= {w_tag_rd, w_idx, {OFF_W{1'b0}}};
          r_line_store  <= r_data[w_idx];
        end else if (mem_done) begin
          r_strb.w_line <= 1'b0;
          if (!w_active)   r_state <= IDLE;
          else if (r_thru) r_state <= r_is_wr ? THRU_WR : THRU_RD;
          else             r_state <= FILL;
        end
        FILL: if (!r_strb.r_line) begin
          r_strb.r_line <= 1'b1;
          mem_addr      <= {w_tag, w_idx, {OFF_W{1'b0}}};
        end else if (mem_done) begin
          r_strb.r_line <= 1'b0;
          r_data[w_idx] <= line_read;
          r_state       <= w_active ? LOOKUP : IDLE;
        end
        THRU_WR: if (!r_strb.w_one) begin
          r_strb.w_one <= 1'b1;
          mem_addr     <= addr;
          r_line_store <= {{((WORDS-1)*32){1'b0}}, data_store};
          if (w_hit) r_data[w_idx][w_off] <= data_store;
        end else if (mem_done) begin
          r_strb.w_one <= 1'b0;
          done         <= w_active;
          cache_hit    <= 1'b0;
          r_state      <= w_active ? RESP : IDLE;
        end
        THRU_RD: if (!r_strb.r_one) begin
          r_strb.r_one <= 1'b1;
          mem_addr     <= addr;
        end else if (mem_done) begin
          r_strb.r_one <= 1'b0;
          data_load    <= line_read[31:0];
          done         <= w_active;
          cache_hit    <= 1'b0;
          r_state      <= w_active ? RESP : IDLE;
        end
        RESP: if (!w_active) begin
          done      <= 1'b0;
          cache_hit <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_cache.sv
// Directed bench for dm_cache: scoreboard of expected responses plus a
// 3-cycle memory model that logs every memory transaction it serves.
module tb_dm_cache;
  logic         clk, rst_l;
  logic         w_en, r_en, write_through, read_through;
  logic [25:0]  addr;
  logic [31:0]  data_store, data_load;
  logic         done, cache_hit;
  logic [25:0]  mem_addr;
  logic         mem_w_line, mem_r_line, mem_w_one, mem_r_one;
  logic [127:0] line_store, line_read;
  logic         mem_done;
`ifdef DM_CACHE_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  dm_cache dut (
    .clk(clk), .rst_l(rst_l), .w_en(w_en), .r_en(r_en),
    .write_through(write_through), .read_through(read_through),
    .addr(addr), .data_store(data_store), .data_load(data_load),
    .done(done), .cache_hit(cache_hit), .mem_addr(mem_addr),
    .mem_w_line(mem_w_line), .mem_r_line(mem_r_line),
    .mem_w_one(mem_w_one), .mem_r_one(mem_r_one),
    .line_store(line_store), .line_read(line_read),
`ifdef DM_CACHE_STATS_EN
    .hit_count(hit_count), .miss_count(miss_count),
`endif
    .mem_done(mem_done)
  );

  typedef struct { logic [1:0] k; logic [25:0] a; logic [127:0] ln; } tx_t;
  typedef struct { logic [31:0] d; bit h; bit wr; } exp_t;
  localparam logic [1:0] K_WL = 2'd0, K_RL = 2'd1, K_WO = 2'd2, K_RO = 2'd3;

  logic [31:0] mem [int unsigned];
  tx_t  obs_tx[$];
  exp_t exp_q[$];
  int   total = 0, bad = 0, n_strb = 0;

  initial begin clk = 0; forever #5 clk = ~clk; end

  function automatic logic [31:0] rd(input int unsigned a);
    return mem.exists(a) ? mem[a] : (32'hD000_0000 | a);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Memory: answers any strobe with mem_done on the third cycle it is seen.
  initial begin
    int cnt = 0;
    int unsigned base;
    mem_done = 0; line_read = '0;
    forever begin
      @(posedge clk); #1;
      mem_done = 0;
      if (!rst_l) cnt = 0;
      else if (mem_w_line | mem_r_line | mem_w_one | mem_r_one) begin
        n_strb++; cnt++;
        if (cnt == 3) begin
          cnt = 0;
          base = {6'd0, mem_addr[25:2], 2'b00};
          if (mem_w_line) begin
            for (int w = 0; w < 4; w++) mem[base + w] = line_store[w*32 +: 32];
            obs_tx.push_back('{k: K_WL, a: mem_addr, ln: line_store});
          end else if (mem_r_line) begin
            for (int w = 0; w < 4; w++) line_read[w*32 +: 32] = rd(base + w);
            obs_tx.push_back('{k: K_RL, a: mem_addr, ln: '0});
          end else if (mem_w_one) begin
            mem[{6'd0, mem_addr}] = line_store[31:0];
            obs_tx.push_back('{k: K_WO, a: mem_addr, ln: line_store});
          end else begin
            line_read = {96'd0, rd({6'd0, mem_addr})};
            obs_tx.push_back('{k: K_RO, a: mem_addr, ln: '0});
          end
          mem_done = 1;
        end
      end else cnt = 0;
    end
  end

  task automatic chk_tx(input string tag, input logic [1:0] k, input logic [25:0] a,
                        output logic [127:0] ln);
    tx_t t;
    ln = '0;
    total++;
    assert (obs_tx.size() != 0) else begin
      bad++;
      $error("FAIL %s: got no memory txn want kind %0d addr %0h", tag, k, a);
    end
    if (obs_tx.size() != 0) begin
      t = obs_tx.pop_front();
      chk({tag, "_kind"}, t.k, k);
      chk({tag, "_addr"}, t.a, a);
      ln = t.ln;
    end
  endtask

  // Issue one request at a negedge, wait (bounded) for done, score it.
  task automatic req(input string tag, input bit wr, input bit thru, input logic [25:0] a,
                     input logic [31:0] d, input logic [31:0] ed, input bit eh, output int lat);
    exp_t e;
    exp_q.push_back('{d: ed, h: eh, wr: wr});
    addr = a; data_store = d; w_en = wr; r_en = !wr;
    write_through = wr && thru; read_through = !wr && thru;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    e = exp_q.pop_front();
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_hit"}, cache_hit, e.h);
    if (!e.wr) chk({tag, "_data"}, data_load, e.d);
    w_en = 0; r_en = 0; write_through = 0; read_through = 0;
    @(negedge clk); @(negedge clk);
  endtask

  initial begin
    int lat, s, c;
    logic [127:0] ln;
    rst_l = 0; w_en = 0; r_en = 0; write_through = 0; read_through = 0;
    addr = '0; data_store = '0;
    #1;
    chk("rst_done", done, 1'b0);
    chk("rst_hit", cache_hit, 1'b0);
    chk("rst_strobes", {mem_w_line, mem_r_line, mem_w_one, mem_r_one}, 4'b0);
    chk("rst_data_load", data_load, 32'd0);
    chk("rst_mem_addr", mem_addr, 26'd0);
    chk("rst_line_store", line_store, 128'd0);
    repeat (2) @(negedge clk);
    rst_l = 1;
    @(negedge clk);

    mem[32'h10] = 32'hA5;
    req("cold_rd", 0, 0, 26'h10, 0, 32'hA5, 0, lat);
    chk_tx("cold_fill", K_RL, 26'h10, ln);
    chk("cold_extra", obs_tx.size(), 0);

    s = n_strb;
    req("wr_hit", 1, 0, 26'h11, 32'h55, 0, 1, lat);
    chk("wr_hit_lat", lat, 2);
    req("rd_hit", 0, 0, 26'h11, 0, 32'h55, 1, lat);
    chk("rd_hit_lat", lat, 2);
    chk("hit_no_strobe", n_strb, s);

    req("evict_rd", 0, 0, 26'h50, 0, rd(32'h50), 0, lat);
    chk_tx("flush", K_WL, 26'h10, ln);
    chk("flush_w1", ln[63:32], 32'h55);
    chk("flush_w0", ln[31:0], 32'hA5);
    chk_tx("refill", K_RL, 26'h50, ln);

    req("wthru", 1, 1, 26'h51, 32'h77, 0, 0, lat);
    chk_tx("wthru_tx", K_WO, 26'h51, ln);
    chk("wthru_word0", ln[31:0], 32'h77);
    s = n_strb;
    req("rd_upd", 0, 0, 26'h51, 0, 32'h77, 1, lat);
    chk("upd_no_strobe", n_strb, s);

    req("clean_evict", 0, 0, 26'h90, 0, rd(32'h90), 0, lat);
    chk_tx("clean_fill", K_RL, 26'h90, ln);
    chk("clean_no_flush", obs_tx.size(), 0);

    req("rthru", 0, 1, 26'h11, 0, 32'h55, 0, lat);
    chk_tx("rthru_tx", K_RO, 26'h11, ln);
    s = n_strb;
    req("no_alloc", 0, 0, 26'h90, 0, rd(32'h90), 1, lat);
    chk("no_alloc_strobe", n_strb, s);

    req("wr_dirty", 1, 0, 26'h92, 32'h33, 0, 1, lat);
    req("rthru_dirty", 0, 1, 26'h92, 0, 32'h33, 0, lat);
    chk_tx("thru_flush", K_WL, 26'h90, ln);
    chk("thru_flush_w2", ln[95:64], 32'h33);
    chk_tx("thru_rd", K_RO, 26'h92, ln);

    // Line is clean after the flush, so the next miss must go straight to FILL.
    addr = 26'hD0; r_en = 1; c = 0;
    while (!(mem_r_line | mem_w_line) && c < 50) begin @(negedge clk); c++; end
    chk("fill_strobe", mem_r_line, 1'b1);
    chk("clean_no_wb", mem_w_line, 1'b0);
    rst_l = 0;
    #1;
    chk("rst_fill_drop", mem_r_line, 1'b0);
    chk("rst_fill_done", done, 1'b0);
    r_en = 0;
    repeat (2) @(negedge clk);
    rst_l = 1;
    @(negedge clk);
    req("rd_after_rst", 0, 0, 26'hD0, 0, rd(32'hD0), 0, lat);
    chk_tx("refetch", K_RL, 26'hD0, ln);
    chk("end_extra", obs_tx.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
